slave: RTL and testbench

//   SPI slave: the responder end of the SPI link driven by the master block. Full-duplex, mode-0-style

---
 rtl/slave_if.sv | 25 ++
 rtl/slave.sv | 91 +++++++++
 tb/tb_slave.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/slave_if.sv
// SPI slave-side bundle: serial lines, parallel word in/out and status pulses.
// CS low frames a transfer; MOSI/MISO are sampled on the sclk rising edge.
interface slave_if #(
  parameter int DATA_W = 8
);
  logic              CS;
  logic              MOSI;
  logic [DATA_W-1:0] SDS;
  logic              MISO;
  logic [DATA_W-1:0] SDO;
  logic              done;
  logic              busy;
  logic              frame_err;
  logic              dbg_state;

  modport master (
    output CS, MOSI, SDS,
    input  MISO, SDO, done, busy, frame_err, dbg_state
  );

  modport slave (
    input  CS, MOSI, SDS,
    output MISO, SDO, done, busy, frame_err, dbg_state
  );
endinterface

// File: rtl/slave.sv
// SPI slave, mode-0 style: full-duplex shift register clocked on sclk rising edge.
// Receives DATA_W bits into SDO and returns the SDS word captured at frame start on MISO.
module slave #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     sclk,
  input  logic     reset,
  slave_if.slave   bus
);
  localparam int             CW   = $clog2(DATA_W);
  localparam logic [CW-1:0]  LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] tx_sh, rx_sh, tx_nx, rx_nx;
  logic [DATA_W-1:0] sdo_q;
  logic [CW-1:0]     bit_cnt;
  logic              done_q, ferr_q;
  logic              last_bit;

  // State register
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: a low CS always means the current edge is a shift edge
  always_comb begin
    state_nx = state;
    if (bus.CS) state_nx = IDLE;
    else        state_nx = SHIFT;
  end

  always_comb begin
    rx_nx = '0;
    tx_nx = '0;
    if (MSB_FIRST) begin
      rx_nx = {rx_sh[DATA_W-2:0], bus.MOSI};
      tx_nx = {tx_sh[DATA_W-2:0], 1'b0};
    end else begin
      rx_nx = {bus.MOSI, rx_sh[DATA_W-1:1]};
      tx_nx = {1'b0, tx_sh[DATA_W-1:1]};
    end
  end

  assign last_bit = (bit_cnt == LAST);

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      sdo_q   <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      if (bus.CS) begin
        // Idle or abort: keep the outgoing word fresh, flag a truncated frame
        tx_sh   <= bus.SDS;
        bit_cnt <= '0;
        ferr_q  <= (bit_cnt != '0);
      end else begin
        rx_sh <= rx_nx;
        if (last_bit) begin
          sdo_q   <= rx_nx;
          done_q  <= 1'b1;
          bit_cnt <= '0;
          tx_sh   <= bus.SDS;
        end else begin
          tx_sh   <= tx_nx;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    bus.MISO      = 1'b0;
    if (!bus.CS) bus.MISO = MSB_FIRST ? tx_sh[DATA_W-1] : tx_sh[0];
    bus.busy      = (bit_cnt != '0);
    bus.SDO       = sdo_q;
    bus.done      = done_q;
    bus.frame_err = ferr_q;
    bus.dbg_state = state;
  end
endmodule

// File: tb/tb_slave.sv
// Directed bench for the SPI slave: one MSB-first and one LSB-first instance on a shared sclk.
module tb_slave;
  logic sclk = 1'b0;
  logic reset;
  always #5 sclk = ~sclk;

  slave_if #(.DATA_W(8)) m_if ();
  slave_if #(.DATA_W(8)) l_if ();

  slave #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (.sclk(sclk), .reset(reset), .bus(m_if.slave));
  slave #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (.sclk(sclk), .reset(reset), .bus(l_if.slave));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  // Driver: called just after a negedge; drives one bit, samples MISO before the edge,
  // then samples registered status after it.
  task automatic send_m(input logic b, output logic miso, output logic dn, output logic fe,
                        output logic bz);
    m_if.CS = 1'b0;
    m_if.MOSI = b;
    #1 miso = m_if.MISO;
    @(posedge sclk);
    @(negedge sclk);
    dn = m_if.done;
    fe = m_if.frame_err;
    bz = m_if.busy;
  endtask

  task automatic idle_m(input int n);
    m_if.CS = 1'b1;
    repeat (n) begin
      @(posedge sclk);
      @(negedge sclk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_if.SDS = 8'hFF;
    m_if.MOSI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_if.CS = i[0];
      @(posedge sclk);
      @(negedge sclk);
      m_if.CS = 1'b0;
      #1;
      n_checks++; if (m_if.MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b exp 0", m_if.MISO); end
      n_checks++; if (m_if.SDO !== 8'h00) begin n_fail++; $display("FAIL reset_sdo got %h exp 00", m_if.SDO); end
      n_checks++; if ({m_if.done, m_if.busy, m_if.frame_err} !== 3'b000) begin
        n_fail++; $display("FAIL reset_flags got %b exp 000", {m_if.done, m_if.busy, m_if.frame_err}); end
    end
    m_if.CS = 1'b1;
    reset = 1'b1;
    idle_m(1);
  endtask

  task automatic test_single();
    logic [7:0] word, mw;
    logic miso, dn, fe, bz;
    int dcnt, dlast, fcnt;
    word = 8'hA5; mw = '0; dcnt = 0; dlast = -1; fcnt = 0;
    m_if.SDS = 8'h3C;
    idle_m(1);
    for (int i = 0; i < 8; i++) begin
      send_m(word[7-i], miso, dn, fe, bz);
      mw[7-i] = miso;
      if (dn) begin dcnt++; dlast = i; end
      if (fe) fcnt++;
      if (i == 3) begin
        n_checks++; if (bz !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid got %b exp 1", bz); end
      end
    end
    n_checks++; if (mw !== 8'h3C) begin n_fail++; $display("FAIL single_miso got %h exp 3c", mw); end
    n_checks++; if (dcnt !== 1 || dlast !== 7) begin n_fail++; $display("FAIL single_done count %0d at %0d exp 1 at 7", dcnt, dlast); end
    n_checks++; if (m_if.SDO !== 8'hA5) begin n_fail++; $display("FAIL single_sdo got %h exp a5", m_if.SDO); end
    n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b exp 0", bz); end
    n_checks++; if (fcnt !== 0) begin n_fail++; $display("FAIL single_ferr got %0d exp 0", fcnt); end
    idle_m(1);
    n_checks++; if (m_if.done !== 1'b0) begin n_fail++; $display("FAIL single_done_clear got %b exp 0", m_if.done); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words, mw;
    logic [7:0] exp_w;
    logic miso, dn, fe, bz;
    logic [15:0] dmask;
    words = 16'h1234; mw = '0; dmask = '0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    m_if.SDS = 8'h55;
    idle_m(1);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) m_if.SDS = 8'hAA;
      send_m(words[15-i], miso, dn, fe, bz);
      mw[15-i] = miso;
      dmask[i] = dn;
      if (dn) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_sdo unexpected done, sdo %h", m_if.SDO); end
        else begin
          exp_w = exp_q.pop_front();
          if (m_if.SDO !== exp_w) begin n_fail++; $display("FAIL b2b_sdo got %h exp %h", m_if.SDO, exp_w); end
        end
      end
    end
    n_checks++; if (dmask !== 16'h8080) begin n_fail++; $display("FAIL b2b_done_mask got %h exp 8080", dmask); end
    n_checks++; if (mw !== 16'h55AA) begin n_fail++; $display("FAIL b2b_miso got %h exp 55aa", mw); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue left %0d exp 0", exp_q.size()); end
    idle_m(1);
  endtask

  task automatic test_abort();
    logic miso, dn, fe, bz;
    logic [7:0] word;
    int dcnt, fcnt;
    dcnt = 0; fcnt = 0; word = 8'h81;
    m_if.SDS = 8'h00;
    for (int i = 0; i < 5; i++) begin
      send_m(1'b1, miso, dn, fe, bz);
      if (dn) dcnt++;
    end
    idle_m(1);
    n_checks++; if (m_if.frame_err !== 1'b1) begin n_fail++; $display("FAIL abort_ferr got %b exp 1", m_if.frame_err); end
    n_checks++; if (m_if.done !== 1'b0 || dcnt !== 0) begin n_fail++; $display("FAIL abort_done got %b/%0d exp 0/0", m_if.done, dcnt); end
    n_checks++; if (m_if.SDO !== 8'h34) begin n_fail++; $display("FAIL abort_sdo got %h exp 34", m_if.SDO); end
    n_checks++; if (m_if.busy !== 1'b0 || m_if.dbg_state !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle busy %b state %b exp 0 0", m_if.busy, m_if.dbg_state); end
    idle_m(1);
    n_checks++; if (m_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL abort_ferr_pulse got %b exp 0", m_if.frame_err); end
    for (int i = 0; i < 8; i++) begin
      send_m(word[7-i], miso, dn, fe, bz);
      if (fe) fcnt++;
    end
    n_checks++; if (m_if.SDO !== 8'h81) begin n_fail++; $display("FAIL abort_next_sdo got %h exp 81", m_if.SDO); end
    idle_m(1);
    n_checks++; if (m_if.frame_err !== 1'b0 || fcnt !== 0) begin
      n_fail++; $display("FAIL clean_end_ferr got %b/%0d exp 0/0", m_if.frame_err, fcnt); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] word, mw;
    int dcnt;
    word = 8'h01; mw = '0; dcnt = 0;
    l_if.SDS = 8'h80;
    l_if.CS = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    for (int i = 0; i < 8; i++) begin
      l_if.CS = 1'b0;
      l_if.MOSI = word[i];
      #1 mw[i] = l_if.MISO;
      @(posedge sclk);
      @(negedge sclk);
      if (l_if.done) dcnt++;
    end
    n_checks++; if (mw !== 8'h80) begin n_fail++; $display("FAIL lsb_miso got %h exp 80", mw); end
    n_checks++; if (l_if.SDO !== 8'h01) begin n_fail++; $display("FAIL lsb_sdo got %h exp 01", l_if.SDO); end
    n_checks++; if (dcnt !== 1) begin n_fail++; $display("FAIL lsb_done got %0d exp 1", dcnt); end
    l_if.CS = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic test_midreset();
    logic miso, dn, fe, bz;
    logic [7:0] word;
    int dcnt;
    word = 8'hC3; dcnt = 0;
    m_if.SDS = 8'h5A;
    for (int i = 0; i < 4; i++) send_m(word[7-i], miso, dn, fe, bz);
    reset = 1'b0;
    #1;
    n_checks++; if (m_if.SDO !== 8'h00 || l_if.SDO !== 8'h00) begin
      n_fail++; $display("FAIL midrst_sdo got %h/%h exp 00/00", m_if.SDO, l_if.SDO); end
    n_checks++; if (m_if.MISO !== 1'b0) begin n_fail++; $display("FAIL midrst_miso got %b exp 0", m_if.MISO); end
    n_checks++; if ({m_if.done, m_if.busy, m_if.frame_err} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_flags got %b exp 000", {m_if.done, m_if.busy, m_if.frame_err}); end
    @(posedge sclk);
    @(negedge sclk);
    m_if.CS = 1'b1;
    reset = 1'b1;
    idle_m(1);
    n_checks++; if (m_if.frame_err !== 1'b0 || m_if.done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_pulse ferr %b done %b exp 0 0", m_if.frame_err, m_if.done); end
    for (int i = 0; i < 8; i++) begin
      send_m(word[7-i], miso, dn, fe, bz);
      if (dn) dcnt++;
    end
    n_checks++; if (m_if.SDO !== 8'hC3 || dcnt !== 1) begin
      n_fail++; $display("FAIL midrst_next_sdo got %h/%0d exp c3/1", m_if.SDO, dcnt); end
    idle_m(1);
  endtask

  initial begin
    reset = 1'b0;
    m_if.CS = 1'b1; m_if.MOSI = 1'b0; m_if.SDS = '0;
    l_if.CS = 1'b1; l_if.MOSI = 1'b0; l_if.SDS = '0;
    repeat (2) @(negedge sclk);
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_lsb_first();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
